ecp5pll_phase_ctrl: RTL and testbench

//  Sequencer for the ECP5 PLL dynamic phase-shift port (ecp5pll with dynamic_en=1).

---
 rtl/ecp5pll_pkg.sv | 23 ++
 rtl/ecp5pll_lock_qual.sv | 44 ++++
 rtl/ecp5pll_phase_ctrl.sv | 154 +++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  typedef logic [1:0] chan_t;

  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ecp5pll_lock_qual.sv
// Lock qualifier: synchronises the PLL lock flag, requires LOCK_CYC consecutive
// locked cycles before declaring stable, and counts stable 1->0 events.
module ecp5pll_lock_qual import ecp5pll_pkg::*; #(
  parameter int LOCK_CYC = 1024
) (
  input  logic       clk_i,
  input  logic       resetn,
  input  logic       locked_i,
  output logic       stable,
  output logic [7:0] lock_loss
);

  localparam int CNT_W = $clog2(LOCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYC);

  logic             sync1;
  logic             sync2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Down-counter reloads whenever synced lock is low; terminal count means qualified.
  assign stable = sync2 && (cnt == '0);

  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= CNT_LOAD;
      stable_q  <= 1'b0;
      lock_loss <= 8'd0;
    end else begin
      sync1    <= locked_i;
      sync2    <= sync1;
      stable_q <= stable;
      if (!sync2)
        cnt <= CNT_LOAD;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (stable_q && !stable && (lock_loss != 8'hFF))
        lock_loss <= lock_loss + 8'd1;
    end
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift port: timed setup/pulse/gap
// generation, per-output phase position tracking, and lock-loss abort handling.
//
//   state | meaning
//   IDLE  | waiting for a request; ready when lock is stable
//   SETUP | phasesel/phasedir settling before the first pulse
//   PULSE | phasestep or phaseloadreg held high
//   GAP   | low time after a pulse; next pulse or finish
//   DONE  | one-cycle completion, done_o (and abort_o) high
module ecp5pll_phase_ctrl import ecp5pll_pkg::*; #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_CYC  = 1024,
  parameter int STEPS_W   = 8,
  parameter int POS_W     = 10
) (
  input  logic               clk_i,
  input  logic               resetn,
  input  logic               locked_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_chan_i,
  input  logic               req_dir_i,
  input  logic [STEPS_W-1:0] req_steps_i,
  input  logic               req_load_i,
  output logic [1:0]         phasesel_o,
  output logic               phasedir_o,
  output logic               phasestep_o,
  output logic               phaseloadreg_o,
  output logic               busy_o,
  output logic               stable_o,
  output logic               done_o,
  output logic               abort_o,
  input  logic [1:0]         pos_chan_i,
  output logic [POS_W-1:0]   pos_o,
  output logic [7:0]         lock_loss_o
);

  localparam int TMR_W = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
  localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] T_PULSE = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(GAP_CYC - 1);

  state_t             state;
  logic               load;
  logic [STEPS_W-1:0] rem;
  logic [TMR_W-1:0]   tmr;
  logic [POS_W-1:0]   pos [4];
  logic               stable;

  ecp5pll_lock_qual #(.LOCK_CYC(LOCK_CYC)) u_lock_qual (
    .clk_i     (clk_i),
    .resetn    (resetn),
    .locked_i  (locked_i),
    .stable    (stable),
    .lock_loss (lock_loss_o)
  );

  assign stable_o    = stable;
  assign busy_o      = (state != IDLE);
  assign req_ready_o = stable && (state == IDLE);
  assign pos_o       = pos[pos_chan_i];

  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      load           <= 1'b0;
      rem            <= '0;
      tmr            <= '0;
      pos            <= '{default: '0};
      phasesel_o     <= 2'd0;
      phasedir_o     <= 1'b0;
      phasestep_o    <= 1'b0;
      phaseloadreg_o <= 1'b0;
      done_o         <= 1'b0;
      abort_o        <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      abort_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            phasesel_o <= req_chan_i;
            phasedir_o <= req_dir_i;
            load       <= req_load_i;
            // A load is one pulse, so it rides the same remaining-step path.
            rem        <= req_load_i ? STEPS_W'(1) : req_steps_i;
            tmr        <= T_SETUP;
            if (!req_load_i && (req_steps_i == '0)) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (!stable) begin
            state   <= DONE;
            done_o  <= 1'b1;
            abort_o <= 1'b1;
          end else if (tmr == '0) begin
            state          <= PULSE;
            tmr            <= T_PULSE;
            phasestep_o    <= !load;
            phaseloadreg_o <= load;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            phasestep_o    <= 1'b0;
            phaseloadreg_o <= 1'b0;
            rem            <= rem - 1'b1;
            tmr            <= T_GAP;
            state          <= GAP;
            if (load)
              pos[phasesel_o] <= '0;
            else if (phasedir_o == DIR_ADVANCE)
              pos[phasesel_o] <= pos[phasesel_o] - 1'b1;
            else
              pos[phasesel_o] <= pos[phasesel_o] + 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        GAP: begin
          if (tmr == '0) begin
            if (!stable || (rem == '0)) begin
              state   <= DONE;
              done_o  <= 1'b1;
              abort_o <= !stable;
            end else begin
              state       <= PULSE;
              tmr         <= T_PULSE;
              phasestep_o <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Self-checking bench for ecp5pll_phase_ctrl: vector table, random requests
// against an arithmetic reference model, and lock-loss / reset corner cases.
module tb_ecp5pll_phase_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 4;
  localparam int LOCK_CYC  = 1024;
  localparam int STEPS_W   = 8;
  localparam int POS_W     = 10;
  localparam int POS_MASK  = (1 << POS_W) - 1;

  logic               clk_i = 1'b0;
  logic               resetn;
  logic               locked_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [1:0]         req_chan_i;
  logic               req_dir_i;
  logic [STEPS_W-1:0] req_steps_i;
  logic               req_load_i;
  logic [1:0]         phasesel_o;
  logic               phasedir_o;
  logic               phasestep_o;
  logic               phaseloadreg_o;
  logic               busy_o;
  logic               stable_o;
  logic               done_o;
  logic               abort_o;
  logic [1:0]         pos_chan_i;
  logic [POS_W-1:0]   pos_o;
  logic [7:0]         lock_loss_o;

  ecp5pll_phase_ctrl #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC),
    .LOCK_CYC(LOCK_CYC), .STEPS_W(STEPS_W), .POS_W(POS_W)
  ) dut (
    .clk_i(clk_i), .resetn(resetn), .locked_i(locked_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_chan_i(req_chan_i), .req_dir_i(req_dir_i),
    .req_steps_i(req_steps_i), .req_load_i(req_load_i),
    .phasesel_o(phasesel_o), .phasedir_o(phasedir_o),
    .phasestep_o(phasestep_o), .phaseloadreg_o(phaseloadreg_o),
    .busy_o(busy_o), .stable_o(stable_o), .done_o(done_o), .abort_o(abort_o),
    .pos_chan_i(pos_chan_i), .pos_o(pos_o), .lock_loss_o(lock_loss_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int model_pos [4];

  typedef struct {
    int chan;
    int dir;
    int steps;
    int load;
    int exp_cyc;
    int exp_steps;
    int exp_loads;
    int exp_pos;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Completion cycle, counting the accept cycle as cycle 1.
  function automatic int model_cyc(input int steps, input int load);
    int n;
    n = load ? 1 : steps;
    if (n == 0) return 2;
    return 2 + SETUP_CYC + n * (PULSE_CYC + GAP_CYC);
  endfunction

  function automatic int model_next_pos(input int p, input int dir, input int n, input int load);
    if (load) return 0;
    return dir ? ((p - n) & POS_MASK) : ((p + n) & POS_MASK);
  endfunction

  task automatic check_positions(input string tag);
    for (int c = 0; c < 4; c++) begin
      pos_chan_i = 2'(c);
      #1;
      chk($sformatf("%s_pos%0d", tag, c), int'(pos_o), model_pos[c]);
    end
  endtask

  // Issues one request and watches the pulse train until done_o.
  task automatic run_req(input int chan, input int dir, input int steps, input int load,
                         input int drop_at, output int cyc, output int nstep,
                         output int nload, output int abort, output int shape_err);
    int wait_n, hi_run, lo_run, first, exp_lo;
    bit done_seen;
    cyc = -1; nstep = 0; nload = 0; abort = -1; shape_err = 0;
    wait_n = 0;
    while (!req_ready_o && wait_n < 3000) begin
      tick();
      wait_n++;
    end
    if (!req_ready_o) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    req_valid_i = 1'b1;
    req_chan_i  = 2'(chan);
    req_dir_i   = 1'(dir);
    req_steps_i = STEPS_W'(steps);
    req_load_i  = 1'(load);
    tick();
    req_valid_i = 1'b0;
    req_steps_i = STEPS_W'($urandom);
    cyc = 2; hi_run = 0; lo_run = 0; first = 1; done_seen = 0;
    for (int n = 0; n < 4000; n++) begin
      if (phasestep_o && phaseloadreg_o) shape_err++;
      if (busy_o && (int'(phasesel_o) != chan)) shape_err++;
      if (busy_o && (int'(phasedir_o) != dir)) shape_err++;
      if (phasestep_o || phaseloadreg_o) begin
        if (hi_run == 0) begin
          exp_lo = first ? SETUP_CYC : GAP_CYC;
          if (lo_run != exp_lo) shape_err++;
          nstep += int'(phasestep_o);
          nload += int'(phaseloadreg_o);
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run != 0) begin
          if (hi_run != PULSE_CYC) shape_err++;
          first = 0;
        end
        hi_run = 0;
        lo_run++;
      end
      if (drop_at != 0 && nstep == drop_at && hi_run == 2) locked_i = 1'b0;
      if (done_o) begin
        done_seen = 1;
        abort = int'(abort_o);
        break;
      end
      tick();
      cyc++;
    end
    if (!done_seen) begin
      chk("done_timeout", 0, 1);
      cyc = -1;
    end
  endtask

  initial begin
    int cyc, nstep, nload, abort, serr, n, chan, dir, steps, load, exp_cyc, ndone;

    vecs[0] = '{2, 0, 3, 0, 28, 3, 0, 3};
    vecs[1] = '{1, 1, 1, 0, 12, 1, 0, 1023};
    vecs[2] = '{1, 0, 0, 1, 12, 0, 1, 0};
    vecs[3] = '{2, 1, 0, 0, 2, 0, 0, 3};
    vecs[4] = '{3, 1, 2, 0, 20, 2, 0, 1022};
    vecs[5] = '{2, 1, 5, 1, 12, 0, 1, 0};

    for (int c = 0; c < 4; c++) model_pos[c] = 0;
    resetn = 1'b0; locked_i = 1'b0; req_valid_i = 1'b0; req_chan_i = 2'd0;
    req_dir_i = 1'b0; req_steps_i = '0; req_load_i = 1'b0; pos_chan_i = 2'd0;
    tick(); tick();

    chk("rst_phasesel", int'(phasesel_o), 0);
    chk("rst_phasedir", int'(phasedir_o), 0);
    chk("rst_phasestep", int'(phasestep_o), 0);
    chk("rst_phaseloadreg", int'(phaseloadreg_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_stable", int'(stable_o), 0);
    chk("rst_ready", int'(req_ready_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_abort", int'(abort_o), 0);
    chk("rst_lock_loss", int'(lock_loss_o), 0);
    check_positions("rst");

    resetn = 1'b1;
    tick();
    locked_i = 1'b1;
    n = 0;
    while (!stable_o && n < 3000) begin
      tick();
      n++;
    end
    chk("lock_qual_edges", n, LOCK_CYC + 2);
    chk("ready_after_lock", int'(req_ready_o), 1);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].chan, vecs[i].dir, vecs[i].steps, vecs[i].load, 0,
              cyc, nstep, nload, abort, serr);
      chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_steps", i), nstep, vecs[i].exp_steps);
      chk($sformatf("vec%0d_loads", i), nload, vecs[i].exp_loads);
      chk($sformatf("vec%0d_abort", i), abort, 0);
      chk($sformatf("vec%0d_shape", i), serr, 0);
      model_pos[vecs[i].chan] = vecs[i].exp_pos;
      tick();
      check_positions($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      chan  = int'($urandom_range(0, 3));
      dir   = int'($urandom_range(0, 1));
      steps = int'($urandom_range(0, 9));
      load  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      exp_cyc = model_cyc(steps, load);
      run_req(chan, dir, steps, load, 0, cyc, nstep, nload, abort, serr);
      chk($sformatf("rnd%0d_cycles", i), cyc, exp_cyc);
      chk($sformatf("rnd%0d_steps", i), nstep, load ? 0 : steps);
      chk($sformatf("rnd%0d_loads", i), nload, load);
      chk($sformatf("rnd%0d_abort", i), abort, 0);
      chk($sformatf("rnd%0d_shape", i), serr, 0);
      model_pos[chan] = model_next_pos(model_pos[chan], dir, steps, load);
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) tick();
      check_positions($sformatf("rnd%0d", i));
    end

    // Lock drops mid pulse 4 of a 10-step burst.
    run_req(0, 0, 10, 0, 4, cyc, nstep, nload, abort, serr);
    chk("loss_cycles", cyc, 2 + SETUP_CYC + 4 * (PULSE_CYC + GAP_CYC));
    chk("loss_steps", nstep, 4);
    chk("loss_abort", abort, 1);
    chk("loss_shape", serr, 0);
    chk("loss_count", int'(lock_loss_o), 1);
    model_pos[0] = model_next_pos(model_pos[0], 0, 4, 0);
    tick();
    chk("loss_ready_low", int'(req_ready_o), 0);
    check_positions("loss");
    locked_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 3000) begin
      tick();
      n++;
    end
    chk("relock_edges", n, LOCK_CYC + 2);

    // Reset in the middle of a burst.
    req_valid_i = 1'b1; req_chan_i = 2'd3; req_dir_i = 1'b0;
    req_steps_i = STEPS_W'(10); req_load_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    n = 0;
    while (!phasestep_o && n < 50) begin
      tick();
      n++;
    end
    chk("mid_burst_pulse", int'(phasestep_o), 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_phasestep", int'(phasestep_o), 0);
    chk("rst_async_busy", int'(busy_o), 0);
    chk("rst_async_stable", int'(stable_o), 0);
    for (int c = 0; c < 4; c++) model_pos[c] = 0;
    check_positions("rst_async");
    @(negedge clk_i);
    resetn = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_o) ndone++;
    end
    chk("rst_no_done", ndone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
